// File: rtl/regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched
//
// Write-port scheduler for a register file shared by two writeback sources.
// After reset it first walks every register address and writes zero to it
// (INIT), then arbitrates between the ALU writeback (requester 0) and the load
// writeback (requester 1) with a round-robin priority bit (RUN).
//
// Ports
//   clock       : sole clock, all state changes on its rising edge
//   reset_n     : synchronous, active-low reset
//   req0_valid  : ALU writeback has a write pending
//   req0_addr   : ALU writeback destination register
//   req0_data   : ALU writeback value
//   req0_ready  : ALU writeback accepted this cycle (combinational)
//   req1_valid  : load writeback has a write pending
//   req1_addr   : load writeback destination register
//   req1_data   : load writeback value
//   req1_ready  : load writeback accepted this cycle (combinational)
//   wren        : register file write enable (registered)
//   write_reg   : register file write address (registered)
//   write_data  : register file write data (registered)
//   init_done   : clear sequence finished, arbitration active
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
  parameter int size      = 32,
  parameter int mem_depth = 32,
  // Guard keeps a one-register configuration from collapsing to a zero-width bus.
  localparam int AW       = (mem_depth > 1) ? $clog2(mem_depth) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [size-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [size-1:0] req1_data,
  output logic            req1_ready,
  output logic            wren,
  output logic [AW-1:0]   write_reg,
  output logic [size-1:0] write_data,
  output logic            init_done
);

  // One spare bit so the counter can represent mem_depth itself without
  // wrapping while the last clear write is issued.
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(mem_depth - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              prio_q,       prio_d;        // 0: requester 0 preferred
  logic              wren_q,       wren_d;
  logic [AW-1:0]     write_reg_q,  write_reg_d;
  logic [size-1:0]   write_data_q, write_data_d;
  logic              init_done_q,  init_done_d;

  logic              grant0;
  logic              grant1;

  // ---------------------------------------------------------------------------
  // Grant logic
  //
  // A requester wins when it is valid and either holds priority or the other
  // side is idle, so a lone requester is served every cycle. Grants are also
  // masked by reset_n: a request presented in a reset cycle must not be
  // acknowledged, because the write it would produce is discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == ST_RUN) && reset_n) begin
      grant0 = req0_valid && (!prio_q || !req1_valid);
      grant1 = req1_valid && ( prio_q || !req0_valid);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree leaves one unassigned and no latch can be inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    prio_d       = prio_q;
    wren_d       = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    init_done_d  = init_done_q;

    case (state_q)
      ST_INIT: begin
        // Clear one register per cycle, ascending from address 0.
        wren_d       = 1'b1;
        write_reg_d  = cnt_q[AW-1:0];
        write_data_d = '0;
        cnt_d        = cnt_q + CNT_W'(1);
        // init_done rises together with the final clear write.
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (grant0) begin
          write_reg_d  = req0_addr;
          write_data_d = req0_data;
          // x0 is hardwired to zero: accept the transfer but drop the write.
          wren_d       = (req0_addr != '0);
          prio_d       = 1'b1;
        end else if (grant1) begin
          write_reg_d  = req1_addr;
          write_data_d = req1_data;
          wren_d       = (req1_addr != '0);
          prio_d       = 1'b0;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the register file contents are not reset here; they are cleared by
  // the INIT write sequence, so only this block's own control state is reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
      wren_q       <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
      wren_q       <= wren_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      init_done_q  <= init_done_d;
    end
  end

  assign wren       = wren_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign init_done  = init_done_q;

endmodule
